uart_transmit: RTL and testbench
================================

Name: uart_transmit

Overview:
- 8N1 UART transmitter with an internal byte FIFO. It is the FPGA->computer counterpart of uart_receive.
- Host-side logic pushes bytes with a valid/ready handshake. The block serialises them onto the tx pin LSB-first at a fixed baud rate.
- It is the return path for the UART programmer (flash readback/acks) and for CPU debug output.
- Single clock domain on clk_100mhz_buffered.

Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- BAUD, 115_200, line bit rate.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  8  byte to send.
- din_valid  input  1  din is presented this cycle.
- din_ready  output  1  FIFO can accept; a push occurs on a rising edge with din_valid && din_ready.
- dout  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte currently shifting.

Behaviour:
- Divisor: DIV = (CLK_FREQ + BAUD/2) / BAUD, an elaboration-time constant (868 at defaults).
  - Every bit, including start and stop, lasts exactly DIV clk cycles.
  - Baud counter width is $clog2(DIV).
- Reset (async assert, sync release): dout=1, din_ready=1, busy=0, fifo_count=0, FSM=IDLE, FIFO pointers cleared.
  - Reset mid-frame drops the frame and returns the line high immediately; no partial byte is resumed.
- FIFO:
  - din_ready = (fifo_count != FIFO_DEPTH). It is registered/derived from registered count, with no combinational path from din_valid.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves fifo_count unchanged.
  - A push to an empty FIFO while the FSM is in IDLE is visible to the FSM on the next edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: dout=1. If FIFO non-empty: pop into shift register, clear baud counter, bit index=0, go to START. dout=0 on the edge after the pop.
  - START: dout=0 for DIV cycles, then go to DATA.
  - DATA: dout=shift[0] for DIV cycles per bit. Shift right after each bit. After bit index 7 completes, go to STOP.
  - STOP: dout=1 for DIV cycles.
    - At the terminal count, if the FIFO is non-empty, pop and go straight to START. This gives back-to-back frames with zero idle gap.
    - Otherwise go to IDLE.
- Latency: din accepted on edge N into an empty FIFO with FSM idle -> pop on edge N+1 -> dout low from edge N+2.
- Frame length: 10*DIV cycles.
- dout is driven from a flop, glitch-free.
- busy = (state != IDLE) || (fifo_count != 0).

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t.
  - function baud_div(clk_freq, baud) returning the rounded divisor, shared with uart_receive.
- Sub-module byte_fifo:
  - Parameterised by DEPTH.
  - Ports: clk, rst, push, pop, wdata, rdata, count, full, empty.
  - Registered rdata available in the same cycle as pop (show-ahead).
- The top FSM and baud counter stay in uart_transmit.

Test Plan (CLK_FREQ=1000, BAUD=100 -> DIV=10, FIFO_DEPTH=4):
- Single byte: push 8'hA5 at edge 0.
  - Required: dout low edges 2-11.
  - Data bits 1,0,1,0,0,1,0,1 for 10 cycles each.
  - High stop bit edges 92-101.
  - busy falls at edge 102; fifo_count returns to 0 at edge 1.
- Back-to-back: push 8'h00 then 8'hFF on consecutive edges.
  - Required: stop of the first frame is followed immediately by the start of the second, with no extra high cycles.
  - Total busy span = 200 cycles.
- Full FIFO: hold din_valid with 6 distinct bytes while the first frame is shifting.
  - Required: din_ready drops after 4 queued (plus 1 popped); 5th queued byte is held until a pop; fifo_count never exceeds 4.
  - Output byte order matches push order.
- Simultaneous push/pop: push exactly on the STOP terminal-count edge with 1 byte queued.
  - Required: fifo_count stays 1 and no byte is lost or duplicated.
- Reset mid-frame: assert rst asynchronously during DATA bit 3.
  - Required: dout=1, busy=0, fifo_count=0 before the next clk edge.
  - After release, the line stays idle until a new push.
- Idle line: no pushes for 1000 cycles after reset.
  - Required: dout constant 1, din_ready=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Rounded clock cycles per bit; also used by uart_receive.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO: rdata always presents the oldest entry, pop retires it.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Occupancy update; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter: byte FIFO feeding a start/data/stop serialiser, LSB first.
module uart_transmit
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    uart_tx_state_t state_q;
    uart_tx_state_t state_d;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [CNT_W-1:0] baud_cnt_d;
    logic [2:0]       bit_idx_q;
    logic [2:0]       bit_idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             dout_q;
    logic             dout_d;
    logic             busy_q;
    logic             busy_d;

    logic             push_s;
    logic             pop_s;
    logic             baud_done_s;
    logic [7:0]       fifo_rdata_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;

    // Ready depends only on the registered occupancy, never on din_valid.
    assign din_ready   = !fifo_full_s;
    assign push_s      = din_valid && !fifo_full_s;
    assign baud_done_s = (baud_cnt_q == CNT_LAST);

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (din),
        .rdata (fifo_rdata_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // State register plus the datapath registers that move with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // Next-state logic; STOP pops directly into START so queued frames run back to back.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    shift_d    = fifo_rdata_s;
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_done_s) begin
                    baud_cnt_d = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_done_s) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_done_s) begin
                    baud_cnt_d = '0;
                    if (!fifo_empty_s) begin
                        pop_s     = 1'b1;
                        shift_d   = fifo_rdata_s;
                        bit_idx_d = 3'd0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the current state; registered below so the line is glitch-free.
    always_comb begin
        dout_d = 1'b1;
        case (state_q)
            IDLE:    dout_d = 1'b1;
            START:   dout_d = 1'b0;
            DATA:    dout_d = shift_q[0];
            STOP:    dout_d = 1'b1;
            default: dout_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE) || (fifo_count_s != '0);
    end

    // Output flops; reset forces the line high at once, dropping any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            busy_q <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign fifo_count = fifo_count_s;

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit: timing table, corner sequences, randomized traffic
// checked by a line-decoding receiver model and byte scoreboard.
module tb_uart_transmit;

    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       dout;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rx_cnt = 0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q [$];
    int start_q [$];

    typedef struct {
        int   edge_n;
        logic exp_dout;
        logic exp_busy;
        int   exp_count;
        logic exp_ready;
    } vec_t;
    vec_t vt [17];

    uart_transmit #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a byte for one edge; it is expected on the line only if ready was high.
    task automatic push(input logic [7:0] b, output bit acc);
        din       = b;
        din_valid = 1'b1;
        acc       = din_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(b);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 3000) begin
            tick(1);
            n++;
        end
        chk({name, "_drain_in_time"}, (n < 3000), 1);
        tick(3);
    endtask

    // Receiver model: finds a start edge, samples each bit at its centre, compares to scoreboard.
    initial begin
        int mc;
        logic [7:0] mb;
        bit act;
        act = 1'b0;
        mc  = 0;
        mb  = 8'd0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || !mon_en) begin
                act = 1'b0;
            end else if (!act) begin
                if (dout === 1'b0) begin
                    act = 1'b1;
                    mc  = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                mc++;
                if (mc == DIV / 2) begin
                    chk("start_bit_mid", dout, 0);
                end else if (mc > DIV / 2 && mc < 9 * DIV + DIV / 2 && (mc - DIV / 2) % DIV == 0) begin
                    mb[(mc - DIV / 2) / DIV - 1] = dout;
                end else if (mc == 9 * DIV + DIV / 2) begin
                    chk("stop_bit_mid", dout, 1);
                    act = 1'b0;
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got byte %h expected none", mb);
                    end else begin
                        chk("rx_byte", mb, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int bad;
        int cur;
        int idx;
        int maxc;
        int gap;
        int tries;
        logic [7:0] fb [6];

        vt[0]  = '{0,   1'b1, 1'b0, 1, 1'b1};
        vt[1]  = '{1,   1'b1, 1'b1, 0, 1'b1};
        vt[2]  = '{2,   1'b0, 1'b1, 0, 1'b1};
        vt[3]  = '{11,  1'b0, 1'b1, 0, 1'b1};
        vt[4]  = '{12,  1'b1, 1'b1, 0, 1'b1};
        vt[5]  = '{21,  1'b1, 1'b1, 0, 1'b1};
        vt[6]  = '{22,  1'b0, 1'b1, 0, 1'b1};
        vt[7]  = '{32,  1'b1, 1'b1, 0, 1'b1};
        vt[8]  = '{42,  1'b0, 1'b1, 0, 1'b1};
        vt[9]  = '{52,  1'b0, 1'b1, 0, 1'b1};
        vt[10] = '{62,  1'b1, 1'b1, 0, 1'b1};
        vt[11] = '{72,  1'b0, 1'b1, 0, 1'b1};
        vt[12] = '{82,  1'b1, 1'b1, 0, 1'b1};
        vt[13] = '{91,  1'b1, 1'b1, 0, 1'b1};
        vt[14] = '{92,  1'b1, 1'b1, 0, 1'b1};
        vt[15] = '{101, 1'b1, 1'b1, 0, 1'b1};
        vt[16] = '{102, 1'b1, 1'b0, 0, 1'b1};
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        rst = 1'b1; din = 8'd0; din_valid = 1'b0;
        tick(3);
        chk("reset_dout", dout, 1);
        chk("reset_busy", busy, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_ready", din_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Idle line for 1000 cycles.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (dout !== 1'b1 || din_ready !== 1'b1) bad++;
        end
        chk("idle_bad_cycles", bad, 0);

        // Single byte 8'hA5 against the timing table.
        push(8'hA5, acc);
        cur = 0;
        for (int i = 0; i < 17; i++) begin
            tick(vt[i].edge_n - cur);
            cur = vt[i].edge_n;
            chk($sformatf("a5_dout_e%0d", cur), dout, vt[i].exp_dout);
            chk($sformatf("a5_busy_e%0d", cur), busy, vt[i].exp_busy);
            chk($sformatf("a5_count_e%0d", cur), fifo_count, vt[i].exp_count);
            chk($sformatf("a5_ready_e%0d", cur), din_ready, vt[i].exp_ready);
        end
        drain("a5");

        // Back-to-back frames with no idle gap.
        start_q.delete();
        push(8'h00, acc);
        push(8'hFF, acc);
        tick(100);
        chk("b2b_stop_e101", dout, 1);
        tick(1);
        chk("b2b_start2_e102", dout, 0);
        tick(99);
        chk("b2b_busy_e201", busy, 1);
        tick(1);
        chk("b2b_busy_e202", busy, 0);
        chk("b2b_dout_e202", dout, 1);
        drain("b2b");
        chk("b2b_frames", start_q.size(), 2);
        if (start_q.size() == 2) chk("b2b_start_spacing", start_q[1] - start_q[0], 100);

        // Full FIFO: six bytes held valid while the first frame shifts.
        idx = 0; maxc = 0;
        din = fb[0]; din_valid = 1'b1;
        for (int c = 0; c <= 110; c++) begin
            acc = din_ready;
            @(posedge clk);
            if (acc && din_valid) begin
                exp_q.push_back(fb[idx]);
                idx++;
            end
            #1;
            if (idx < 6) din = fb[idx];
            else din_valid = 1'b0;
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            if (c == 4) begin
                chk("full_count_e4", fifo_count, 4);
                chk("full_ready_e4", din_ready, 0);
            end
            if (c == 100) chk("full_ready_e100", din_ready, 0);
            if (c == 101) begin
                chk("full_count_e101", fifo_count, 3);
                chk("full_ready_e101", din_ready, 1);
            end
            if (c == 102) begin
                chk("full_count_e102", fifo_count, 4);
                chk("full_ready_e102", din_ready, 0);
            end
        end
        din_valid = 1'b0;
        chk("full_all_accepted", idx, 6);
        chk("full_max_count", maxc, 4);
        drain("full");

        // Push on the STOP terminal edge with one byte queued.
        start_q.delete();
        push(8'h5A, acc);
        push(8'hC7, acc);
        tick(99);
        chk("simul_count_e100", fifo_count, 1);
        push(8'h3E, acc);
        chk("simul_accepted", acc, 1);
        chk("simul_count_e101", fifo_count, 1);
        drain("simul");
        chk("simul_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("simul_gap1", start_q[1] - start_q[0], 100);
            chk("simul_gap2", start_q[2] - start_q[1], 100);
        end

        // Asynchronous reset during data bit 3, with a second byte queued.
        push(8'h3C, acc);
        push(8'hC3, acc);
        tick(44);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_mid_dout", dout, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_count", fifo_count, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (dout !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("rst_after_idle_bad", bad, 0);

        // Randomized traffic with mixed short and long gaps.
        rx_cnt = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(50, 150)) : int'($urandom_range(0, 2));
            if (gap > 0) tick(gap);
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 500) begin
                push(8'($urandom), acc);
                tries++;
                if (int'(fifo_count) > DEPTH) bad++;
                if (din_ready !== (fifo_count != 3'(DEPTH))) bad++;
            end
            if (!acc) bad++;
        end
        chk("rand_fifo_invariants", bad, 0);
        drain("rand");
        chk("rand_rx_count", rx_cnt, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
